vga_pattern_gen: RTL and testbench
==================================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter BOX_SIZE, default 32, SHALL set the side length in pixels of the moving box in pattern 3.
REQ-002 Parameter CHK_BIT, default 5, SHALL set the position bit for checkerboard square size; the default gives 32-pixel squares.
REQ-003 CLK  in  1  SHALL be the system clock.
REQ-004 RST  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 PIX_EN  in  1  SHALL be a pixel-advance enable; all pipeline and state updates occur only on CLK edges where PIX_EN=1.
REQ-006 DISP_ACTIVE_I, HSYNC_I, VSYNC_I  in  1 each  SHALL be the timing-stage active flag and syncs.
REQ-007 XPOS, YPOS  in  12 each  SHALL be the current pixel position from the timing stage.
REQ-008 H_VIS, V_VIS  in  12 each  SHALL be the visible width and visible height for the current mode.
REQ-009 PAT_SEL  in  2  SHALL select the pattern: 0 solid red, 1 colour bars, 2 checkerboard, 3 moving box.
REQ-010 HSYNC, VSYNC, DISP_ACTIVE  out  1 each  SHALL be the delayed sync and active signals, aligned to RGB.
REQ-011 Ro, Go, Bo  out  4 each  SHALL be the pixel colour.
REQ-012 FRAME_CNT  out  8  SHALL be a free-running frame counter.

Function
REQ-013 Fixed two-stage pipeline, advanced by PIX_EN: stage 1 registers position, active flag, syncs and pattern decode inputs; stage 2 registers the final RGB, syncs and active flag.
REQ-014 Outputs SHALL equal the inputs of exactly 2 PIX_EN pulses earlier; sync/active/RGB SHALL never be misaligned.
REQ-015 Frame start (FS) SHALL be the PIX_EN cycle with XPOS=0 and YPOS=0.
REQ-016 At FS, FRAME_CNT SHALL increment mod 256 (255 -> 0).
REQ-017 PAT_SEL SHALL be sampled into an active-pattern register only at FS; changes mid-frame SHALL have no effect until the next FS.
REQ-018 When the stage-2 active flag is 0, RGB SHALL be 0/0/0 regardless of pattern.
REQ-019 Pattern 0 SHALL output R=F, G=0, B=0.
REQ-020 Pattern 1 SHALL output 8 vertical bars with bar width W = H_VIS>>3.
REQ-021 Pattern 1 bar tracking: a per-line counter and a 3-bit bar index SHALL clear when XPOS=0; the counter SHALL count active pixels, and when it reaches W-1 it SHALL clear and the index SHALL increment, saturating at 7.
REQ-022 Pattern 1 colours: bar index i maps to {R,G,B} = {i[2],i[1],i[0]} with each bit expanded to 4'hF or 4'h0, so bar 0 is black and bar 7 is white.
REQ-023 Pattern 2 SHALL output white when XPOS[CHK_BIT]^YPOS[CHK_BIT]=1, else black.
REQ-024 Pattern 3 SHALL output blue background with a green BOX_SIZE×BOX_SIZE box; the box covers a pixel when BX<=XPOS<BX+BOX_SIZE and BY<=YPOS<BY+BOX_SIZE.
REQ-025 Box position BX, BY (12-bit) SHALL update only at FS, moving 1 pixel per frame in each axis by direction bits DX, DY (1 = increasing).
REQ-026 Box bounce, X axis: if DX=1 and BX+BOX_SIZE>=H_VIS, DX SHALL flip to 0 and BX SHALL decrement that frame.
REQ-027 Box bounce, X axis: if DX=0 and BX=0, DX SHALL flip to 1 and BX SHALL increment that frame.
REQ-028 Box bounce, Y axis SHALL follow the same rules as X, using V_VIS.
REQ-029 If H_VIS or V_VIS shrinks (mode change) so that the box lies out of range, the next FS SHALL clamp BX to H_VIS-BOX_SIZE and BY to V_VIS-BOX_SIZE, and set the directions to decreasing.
REQ-030 Box comparisons SHALL use 13-bit arithmetic so that no sum wraps.
REQ-031 With PIX_EN=0, all registers SHALL hold their values.

Reset
REQ-032 While RST=1, all outputs SHALL be 0: HSYNC, VSYNC, DISP_ACTIVE, Ro, Go, Bo, FRAME_CNT.
REQ-033 While RST=1, internal state SHALL be: BX=BY=0, DX=DY=1, active pattern 0, bar counter and index 0, pipeline cleared.
REQ-034 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-035 After RST deasserts, output SHALL begin at the next FS.

Verification
REQ-036 640×480 timing, PAT_SEL=0, PIX_EN every 2nd cycle -> RGB=F/0/0 while active and 0 in blanking; HSYNC/VSYNC/DISP_ACTIVE equal the inputs delayed by 2 PIX_EN pulses.
REQ-037 PAT_SEL=1, H_VIS=640 -> bar index changes at XPOS=80,160,...,560 (seen at the output 2 pulses later); XPOS 0-79 black, 560-639 white.
REQ-038 PAT_SEL switched 0->2 at YPOS=200 -> frame completes solid red; the next frame is a checkerboard, with (XPOS=32,YPOS=0) white and (32,32) black.
REQ-039 PAT_SEL=3, 800×600, run 800 frames -> BX reaches 768, then decreases; DX flips exactly once near frame 768; BY bounces at 568; FRAME_CNT wraps 255->0.
REQ-040 With BX=700, switch H_VIS 800->640 -> at the next FS, BX=608 and DX=0.
REQ-041 Assert RST for 3 cycles mid-line -> outputs 0 immediately; BX=0, FRAME_CNT=0; normal output resumes at the next FS.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern source placed behind a VGA timing stage (solid, bars, checker, box).
// Latency: 2 PIX_EN pulses from timing inputs to HSYNC/VSYNC/DISP_ACTIVE/RGB, all kept aligned.
// No backpressure: PIX_EN is the only advance and every register holds while it is low.
module vga_pattern_gen #(
  parameter int BOX_SIZE = 32,
  parameter int CHK_BIT  = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PIX_EN,
  input  logic        DISP_ACTIVE_I,
  input  logic        HSYNC_I,
  input  logic        VSYNC_I,
  input  logic [11:0] XPOS,
  input  logic [11:0] YPOS,
  input  logic [11:0] H_VIS,
  input  logic [11:0] V_VIS,
  input  logic [1:0]  PAT_SEL,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DISP_ACTIVE,
  output logic [3:0]  Ro,
  output logic [3:0]  Go,
  output logic [3:0]  Bo,
  output logic [7:0]  FRAME_CNT
);

  localparam logic [12:0] BOX13 = 13'(BOX_SIZE);

  // frame-level state, only touched at frame start
  logic [1:0]  r_pat;
  logic        r_run;
  logic [11:0] r_bx;
  logic [11:0] r_by;
  logic        r_dx;
  logic        r_dy;

  // colour-bar tracking for the pixel about to arrive
  logic [11:0] r_bar_cnt;
  logic [2:0]  r_bar_idx;

  // stage 1
  logic        r_s1_act;
  logic        r_s1_hs;
  logic        r_s1_vs;
  logic [11:0] r_s1_x;
  logic [11:0] r_s1_y;
  logic [2:0]  r_s1_bar;

  logic        w_fs;
  logic        w_run;
  logic [11:0] w_bar_w;
  logic [11:0] w_cnt_cur;
  logic [2:0]  w_idx_cur;
  logic        w_bar_last;
  logic [11:0] w_bx_nxt;
  logic [11:0] w_by_nxt;
  logic        w_dx_nxt;
  logic        w_dy_nxt;
  logic        w_in_box;
  logic        w_chk;
  logic [11:0] w_rgb;

  // One axis of box motion; 13-bit sums so pos+BOX_SIZE never wraps.
  // A box that no longer fits (mode shrink) is clamped to the far edge and sent back.
  function automatic logic [12:0] box_step(input logic [11:0] pos, input logic dir,
                                           input logic [11:0] vis);
    logic [12:0] pos13;
    logic [12:0] end13;
    logic [12:0] vis13;
    logic [12:0] lim13;
    logic [11:0] pos_n;
    logic        dir_n;
    pos13 = {1'b0, pos};
    end13 = pos13 + BOX13;
    vis13 = {1'b0, vis};
    lim13 = vis13 - BOX13;
    pos_n = pos;
    dir_n = dir;
    if (end13 > vis13) begin
      pos_n = (vis13 >= BOX13) ? lim13[11:0] : 12'd0;
      dir_n = 1'b0;
    end else if (dir) begin
      if (end13 == vis13) begin
        dir_n = 1'b0;
        pos_n = (pos == 12'd0) ? 12'd0 : pos - 12'd1;
      end else begin
        pos_n = pos + 12'd1;
      end
    end else if (pos == 12'd0) begin
      dir_n = 1'b1;
      pos_n = 12'd1;
    end else begin
      pos_n = pos - 12'd1;
    end
    return {dir_n, pos_n};
  endfunction

  assign w_fs       = PIX_EN && (XPOS == 12'd0) && (YPOS == 12'd0);
  // Output stays dark after reset until the first frame start reaches the pipeline.
  assign w_run      = r_run | w_fs;
  assign w_bar_w    = H_VIS >> 3;
  assign w_cnt_cur  = (XPOS == 12'd0) ? 12'd0 : r_bar_cnt;
  assign w_idx_cur  = (XPOS == 12'd0) ? 3'd0 : r_bar_idx;
  assign w_bar_last = (w_cnt_cur == (w_bar_w - 12'd1));

  assign {w_dx_nxt, w_bx_nxt} = box_step(r_bx, r_dx, H_VIS);
  assign {w_dy_nxt, w_by_nxt} = box_step(r_by, r_dy, V_VIS);

  assign w_in_box = ({1'b0, r_s1_x} >= {1'b0, r_bx}) && ({1'b0, r_s1_x} < ({1'b0, r_bx} + BOX13)) &&
                    ({1'b0, r_s1_y} >= {1'b0, r_by}) && ({1'b0, r_s1_y} < ({1'b0, r_by} + BOX13));
  assign w_chk    = r_s1_x[CHK_BIT] ^ r_s1_y[CHK_BIT];

  // Frame start: count frame, latch pattern, move the box, enable output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FRAME_CNT <= 8'd0;
      r_pat     <= 2'd0;
      r_run     <= 1'b0;
      r_bx      <= 12'd0;
      r_by      <= 12'd0;
      r_dx      <= 1'b1;
      r_dy      <= 1'b1;
    end else if (w_fs) begin
      FRAME_CNT <= FRAME_CNT + 8'd1;
      r_pat     <= PAT_SEL;
      r_run     <= 1'b1;
      r_bx      <= w_bx_nxt;
      r_by      <= w_by_nxt;
      r_dx      <= w_dx_nxt;
      r_dy      <= w_dy_nxt;
    end
  end

  // Bar counter/index: restart each line, step the index every W active pixels, saturate at 7.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_bar_cnt <= 12'd0;
      r_bar_idx <= 3'd0;
    end else if (PIX_EN) begin
      if (DISP_ACTIVE_I && w_bar_last) begin
        r_bar_cnt <= 12'd0;
        r_bar_idx <= (w_idx_cur == 3'd7) ? 3'd7 : w_idx_cur + 3'd1;
      end else if (DISP_ACTIVE_I) begin
        r_bar_cnt <= w_cnt_cur + 12'd1;
        r_bar_idx <= w_idx_cur;
      end else begin
        r_bar_cnt <= w_cnt_cur;
        r_bar_idx <= w_idx_cur;
      end
    end
  end

  // Stage 1: capture timing, position and bar index for the incoming pixel.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1_act <= 1'b0;
      r_s1_hs  <= 1'b0;
      r_s1_vs  <= 1'b0;
      r_s1_x   <= 12'd0;
      r_s1_y   <= 12'd0;
      r_s1_bar <= 3'd0;
    end else if (PIX_EN) begin
      r_s1_act <= DISP_ACTIVE_I & w_run;
      r_s1_hs  <= HSYNC_I & w_run;
      r_s1_vs  <= VSYNC_I & w_run;
      r_s1_x   <= XPOS;
      r_s1_y   <= YPOS;
      r_s1_bar <= w_idx_cur;
    end
  end

  // Pattern decode from stage-1 values; black outside the active area.
  always_comb begin
    w_rgb = 12'h000;
    if (r_s1_act) begin
      case (r_pat)
        2'd0:    w_rgb = 12'hF00;
        2'd1:    w_rgb = {{4{r_s1_bar[2]}}, {4{r_s1_bar[1]}}, {4{r_s1_bar[0]}}};
        2'd2:    w_rgb = w_chk ? 12'hFFF : 12'h000;
        default: w_rgb = w_in_box ? 12'h0F0 : 12'h00F;
      endcase
    end
  end

  // Stage 2: registered outputs, syncs and colour move together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      HSYNC       <= 1'b0;
      VSYNC       <= 1'b0;
      DISP_ACTIVE <= 1'b0;
      Ro          <= 4'h0;
      Go          <= 4'h0;
      Bo          <= 4'h0;
    end else if (PIX_EN) begin
      HSYNC          <= r_s1_hs;
      VSYNC          <= r_s1_vs;
      DISP_ACTIVE    <= r_s1_act;
      {Ro, Go, Bo}   <= w_rgb;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: drives pixels directly, predicts each output from a frame-level model.
// Expected {hsync,vsync,active,rgb} is queued when a pixel is driven and popped 2 pulses later.
// PIX_EN is pulsed by the bench; gaps between pulses are used to check that outputs hold.
module tb_vga_pattern_gen;

  localparam int BOX = 32;
  localparam int CHK = 5;

  localparam int SOL_X[11] = '{0, 1, 2, 320, 638, 639, 640, 655, 656, 700, 799};
  localparam int SOL_Y[7]  = '{0, 1, 240, 479, 480, 490, 524};
  localparam int SW_ROW[6] = '{0, 100, 199, 200, 300, 479};
  localparam int SW_COL[4] = '{0, 32, 64, 639};
  localparam int CK_X[9]   = '{0, 32, 32, 0, 63, 64, 31, 100, 700};
  localparam int CK_Y[9]   = '{0, 0, 32, 32, 0, 0, 31, 479, 479};
  localparam int RS_X[7]   = '{0, 1, 32, 33, 1, 1, 1};
  localparam int RS_Y[7]   = '{1, 1, 1, 1, 0, 32, 33};

  logic        CLK;
  logic        RST;
  logic        PIX_EN;
  logic        DISP_ACTIVE_I;
  logic        HSYNC_I;
  logic        VSYNC_I;
  logic [11:0] XPOS;
  logic [11:0] YPOS;
  logic [11:0] H_VIS;
  logic [11:0] V_VIS;
  logic [1:0]  PAT_SEL;
  logic        HSYNC;
  logic        VSYNC;
  logic        DISP_ACTIVE;
  logic [3:0]  Ro;
  logic [3:0]  Go;
  logic [3:0]  Bo;
  logic [7:0]  FRAME_CNT;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [14:0] v;
  } sb_t;

  sb_t sb[$];
  int total = 0;
  int bad   = 0;

  int         m_bx;
  int         m_by;
  int         m_fcnt;
  bit         m_dx;
  bit         m_dy;
  bit         m_run;
  logic [1:0] m_pat;

  vga_pattern_gen #(.BOX_SIZE(BOX), .CHK_BIT(CHK)) dut (
    .CLK(CLK), .RST(RST), .PIX_EN(PIX_EN),
    .DISP_ACTIVE_I(DISP_ACTIVE_I), .HSYNC_I(HSYNC_I), .VSYNC_I(VSYNC_I),
    .XPOS(XPOS), .YPOS(YPOS), .H_VIS(H_VIS), .V_VIS(V_VIS), .PAT_SEL(PAT_SEL),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .DISP_ACTIVE(DISP_ACTIVE),
    .Ro(Ro), .Go(Go), .Bo(Bo), .FRAME_CNT(FRAME_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] out_now();
    return {HSYNC, VSYNC, DISP_ACTIVE, Ro, Go, Bo};
  endfunction

  task automatic model_reset();
    m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    m_fcnt = 0; m_run = 0; m_pat = 2'd0;
    sb.delete();
  endtask

  // Box motion along one axis, written straight from the bounce/clamp rules.
  task automatic model_axis(inout int p, inout bit d, input int vis);
    if (p + BOX > vis) begin
      p = (vis >= BOX) ? vis - BOX : 0;
      d = 0;
    end else if (d) begin
      if (p + BOX >= vis) begin
        d = 0;
        if (p > 0) p = p - 1;
      end else begin
        p = p + 1;
      end
    end else if (p == 0) begin
      d = 1;
      p = 1;
    end else begin
      p = p - 1;
    end
  endtask

  task automatic model_fs();
    m_run  = 1;
    m_fcnt = (m_fcnt + 1) % 256;
    m_pat  = PAT_SEL;
    model_axis(m_bx, m_dx, int'(H_VIS));
    model_axis(m_by, m_dy, int'(V_VIS));
  endtask

  function automatic logic [14:0] model_pix(int x, int y, logic a, logic hs, logic vs);
    logic [11:0] rgb;
    logic [2:0]  i3;
    int          w;
    int          idx;
    rgb = 12'h000;
    if (!m_run) return 15'h0;
    if (a) begin
      case (m_pat)
        2'd0: rgb = 12'hF00;
        2'd1: begin
          w   = int'(H_VIS >> 3);
          idx = (w == 0) ? 0 : x / w;
          if (idx > 7) idx = 7;
          i3  = 3'(idx);
          rgb = {{4{i3[2]}}, {4{i3[1]}}, {4{i3[0]}}};
        end
        2'd2: rgb = ((((x >> CHK) ^ (y >> CHK)) & 1) == 1) ? 12'hFFF : 12'h000;
        default: rgb = (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX) ?
                       12'h0F0 : 12'h00F;
      endcase
    end
    return {hs, vs, a, rgb};
  endfunction

  // Present one pixel for one PIX_EN pulse; return the output after the edge and
  // the expectation that belongs to it (the pixel driven on the previous pulse).
  task automatic pix(input int x, input int y, input logic a, input logic hs, input logic vs,
                     output logic vld, output logic [14:0] got, output sb_t exp);
    sb_t e;
    XPOS = 12'(x); YPOS = 12'(y);
    DISP_ACTIVE_I = a; HSYNC_I = hs; VSYNC_I = vs;
    PIX_EN = 1'b1;
    if (x == 0 && y == 0) model_fs();
    e.x = 12'(x);
    e.y = 12'(y);
    e.v = model_pix(x, y, a, hs, vs);
    sb.push_back(e);
    @(posedge CLK); #1;
    PIX_EN = 1'b0;
    got = out_now();
    vld = (sb.size() >= 2);
    exp = vld ? sb.pop_front() : '0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #2;
    total++;
    if ({out_now(), FRAME_CNT} !== 23'd0) begin
      bad++;
      $display("FAIL reset_async got=%h fcnt=%0d want 0", out_now(), FRAME_CNT);
    end
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({out_now(), FRAME_CNT} !== 23'd0) begin
      bad++;
      $display("FAIL reset_hold got=%h fcnt=%0d want 0", out_now(), FRAME_CNT);
    end
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_solid();
    logic v; logic [14:0] g; sb_t e;
    int x; int y;
    H_VIS = 12'd640; V_VIS = 12'd480; PAT_SEL = 2'd0;
    // pixels before the first frame start must stay dark
    for (int i = 0; i < 3; i++) begin
      pix(100 + i, 100, 1'b1, 1'b1, 1'b1, v, g, e);
      if (v) begin
        total++;
        if (g !== e.v) begin
          bad++;
          $display("FAIL pre_fs x=%0d y=%0d got=%h want=%h", e.x, e.y, g, e.v);
        end
      end
    end
    for (int yi = 0; yi < 7; yi++) begin
      for (int xi = 0; xi < 11; xi++) begin
        x = SOL_X[xi]; y = SOL_Y[yi];
        pix(x, y, (x < 640 && y < 480), (x >= 656 && x < 752), (y >= 490 && y < 492), v, g, e);
        @(posedge CLK); #1;
        if (v) begin
          total++;
          if (g !== e.v) begin
            bad++;
            $display("FAIL solid x=%0d y=%0d got=%h want=%h", e.x, e.y, g, e.v);
          end
          total++;
          if (out_now() !== e.v) begin
            bad++;
            $display("FAIL solid_hold x=%0d y=%0d got=%h want=%h", e.x, e.y, out_now(), e.v);
          end
        end
      end
    end
  endtask

  task automatic test_bars();
    logic v; logic [14:0] g; sb_t e;
    PAT_SEL = 2'd1;
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 800; x++) begin
        pix(x, y, (x < 640), 1'b0, 1'b0, v, g, e);
        if (v) begin
          total++;
          if (g !== e.v) begin
            bad++;
            $display("FAIL bars x=%0d y=%0d got=%h want=%h", e.x, e.y, g, e.v);
          end
        end
      end
    end
  endtask

  task automatic test_pat_switch();
    logic v; logic [14:0] g; sb_t e;
    int x; int y;
    PAT_SEL = 2'd0;
    for (int r = 0; r < 6; r++) begin
      if (SW_ROW[r] == 200) PAT_SEL = 2'd2;
      for (int c = 0; c < 4; c++) begin
        x = SW_COL[c]; y = SW_ROW[r];
        pix(x, y, 1'b1, 1'b0, 1'b0, v, g, e);
        if (v) begin
          total++;
          if (g !== e.v) begin
            bad++;
            $display("FAIL switch_old x=%0d y=%0d got=%h want=%h", e.x, e.y, g, e.v);
          end
        end
      end
    end
    for (int i = 0; i < 9; i++) begin
      x = CK_X[i]; y = CK_Y[i];
      pix(x, y, (x < 640 && y < 480), 1'b0, 1'b0, v, g, e);
      if (v) begin
        total++;
        if (g !== e.v) begin
          bad++;
          $display("FAIL checker x=%0d y=%0d got=%h want=%h", e.x, e.y, g, e.v);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic v; logic [14:0] g; sb_t e;
    pix(200, 100, 1'b1, 1'b0, 1'b0, v, g, e);
    pix(201, 100, 1'b1, 1'b0, 1'b0, v, g, e);
    RST = 1'b1;
    #1;
    total++;
    if ({out_now(), FRAME_CNT} !== 23'd0) begin
      bad++;
      $display("FAIL midreset_async got=%h fcnt=%0d want 0", out_now(), FRAME_CNT);
    end
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({out_now(), FRAME_CNT} !== 23'd0) begin
      bad++;
      $display("FAIL midreset_hold got=%h fcnt=%0d want 0", out_now(), FRAME_CNT);
    end
    RST = 1'b0;
    model_reset();
    for (int x = 300; x < 305; x++) begin
      pix(x, 100, 1'b1, 1'b1, 1'b0, v, g, e);
      if (v) begin
        total++;
        if (g !== e.v) begin
          bad++;
          $display("FAIL midreset_dark x=%0d y=%0d got=%h want=%h", e.x, e.y, g, e.v);
        end
      end
    end
    // resume on a box frame: box must restart from the reset position
    PAT_SEL = 2'd3; H_VIS = 12'd800; V_VIS = 12'd600;
    pix(0, 0, 1'b1, 1'b0, 1'b0, v, g, e);
    total++;
    if (FRAME_CNT !== 8'(m_fcnt)) begin
      bad++;
      $display("FAIL midreset_fcnt got=%0d want=%0d", FRAME_CNT, m_fcnt);
    end
    for (int i = 0; i < 7; i++) begin
      pix(RS_X[i], RS_Y[i], 1'b1, 1'b0, 1'b0, v, g, e);
      if (v) begin
        total++;
        if (g !== e.v) begin
          bad++;
          $display("FAIL midreset_box x=%0d y=%0d got=%h want=%h", e.x, e.y, g, e.v);
        end
      end
    end
  endtask

  task automatic test_box();
    logic v; logic [14:0] g; sb_t e;
    int px[6]; int py[6];
    for (int f = 0; f < 800; f++) begin
      pix(0, 0, 1'b1, 1'b0, 1'b0, v, g, e);
      if (v) begin
        total++;
        if (g !== e.v) begin
          bad++;
          $display("FAIL box x=%0d y=%0d got=%h want=%h", e.x, e.y, g, e.v);
        end
      end
      total++;
      if (FRAME_CNT !== 8'(m_fcnt)) begin
        bad++;
        $display("FAIL box_fcnt frame=%0d got=%0d want=%0d", f, FRAME_CNT, m_fcnt);
      end
      px = '{m_bx - 1, m_bx, m_bx + 31, m_bx + 32, m_bx, m_bx};
      py = '{m_by, m_by, m_by + 31, m_by + 31, m_by - 1, m_by + 32};
      for (int i = 0; i < 6; i++) begin
        if (px[i] >= 0 && py[i] >= 0 && !(px[i] == 0 && py[i] == 0)) begin
          pix(px[i], py[i], (px[i] < 800 && py[i] < 600), 1'b0, 1'b0, v, g, e);
          if (v) begin
            total++;
            if (g !== e.v) begin
              bad++;
              $display("FAIL box x=%0d y=%0d got=%h want=%h", e.x, e.y, g, e.v);
            end
          end
        end
      end
    end
  endtask

  task automatic test_mode_change();
    logic v; logic [14:0] g; sb_t e;
    int px[4];
    int n = 0;
    while (m_bx != 700 && n < 100) begin
      pix(0, 0, 1'b1, 1'b0, 1'b0, v, g, e);
      if (v) begin
        total++;
        if (g !== e.v) begin
          bad++;
          $display("FAIL mode_run x=%0d y=%0d got=%h want=%h", e.x, e.y, g, e.v);
        end
      end
      pix(900, 0, 1'b0, 1'b0, 1'b0, v, g, e);
      if (v) begin
        total++;
        if (g !== e.v) begin
          bad++;
          $display("FAIL mode_run x=%0d y=%0d got=%h want=%h", e.x, e.y, g, e.v);
        end
      end
      n++;
    end
    total++;
    if (m_bx != 700) begin
      bad++;
      $display("FAIL mode_setup frames=%0d bx=%0d want 700", n, m_bx);
    end
    H_VIS = 12'd640;
    for (int fr = 0; fr < 2; fr++) begin
      pix(0, 0, 1'b1, 1'b0, 1'b0, v, g, e);
      if (v) begin
        total++;
        if (g !== e.v) begin
          bad++;
          $display("FAIL mode x=%0d y=%0d got=%h want=%h", e.x, e.y, g, e.v);
        end
      end
      px = (fr == 0) ? '{607, 608, 639, 640} : '{606, 607, 638, 639};
      for (int i = 0; i < 5; i++) begin
        if (i < 4) pix(px[i], m_by, (px[i] < 640), 1'b0, 1'b0, v, g, e);
        else       pix(900, 1, 1'b0, 1'b0, 1'b0, v, g, e);
        if (v) begin
          total++;
          if (g !== e.v) begin
            bad++;
            $display("FAIL mode x=%0d y=%0d got=%h want=%h", e.x, e.y, g, e.v);
          end
        end
      end
    end
  endtask

  initial begin
    RST = 1'b0; PIX_EN = 1'b0;
    DISP_ACTIVE_I = 1'b0; HSYNC_I = 1'b0; VSYNC_I = 1'b0;
    XPOS = 12'd5; YPOS = 12'd5; H_VIS = 12'd640; V_VIS = 12'd480; PAT_SEL = 2'd0;
    model_reset();
    #1;
    test_reset();
    test_solid();
    test_bars();
    test_pat_switch();
    test_reset_mid();
    test_box();
    test_mode_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
